// File: rtl/mux_pkg.sv
// Shared definitions for the mux select arbiter and the 2:1 mux bench:
// arbiter state encoding, select constants and the idle-time pick rule.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        GAP     = 2'd3
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Choice made when nobody owns the mux: a lone requester wins, and on a
    // tie the source that did not own the mux last time wins.
    function automatic arb_state_e idle_pick(input logic req_a,
                                             input logic req_b,
                                             input logic last);
        arb_state_e result;
        result = IDLE;
        if (req_a && req_b) begin
            result = (last == SEL_A) ? GRANT_B : GRANT_A;
        end else if (req_a) begin
            result = GRANT_A;
        end else if (req_b) begin
            result = GRANT_B;
        end
        return result;
    endfunction

    // Mux select value that belongs to a grant state.
    function automatic logic grant_sel(input arb_state_e s);
        return (s == GRANT_B) ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of
// wrapping. Clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-source arbiter driving the select of a 2:1 mux. Grants one source at a
// time, holds a grant for a minimum time under contention, alternates on
// contention, and inserts a dead gap (both grants low) before every
// switchover so the mux never changes source under an active grant.
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    output logic             sel,
    output logic             grant_a,
    output logic             grant_b,
    output logic [CNT_W-1:0] switch_cnt
);

    // Hold and gap counters count the cycles spent in the current grant or
    // gap including the present one, so they stop at their limit.
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);

    arb_state_e state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic       grant_a_q, grant_b_q;
    logic       switch_inc;
    logic       other_req;
    logic       grant_next;
    arb_state_e pick;
    logic [HW-1:0] hold_q;
    logic [GW-1:0] gap_q;

    assign grant_next = (state_d == GRANT_A) || (state_d == GRANT_B);

    // Minimum-hold timer: starts at 1 on the edge a grant rises.
    sat_counter #(.W(HW)) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!grant_next),
        .inc   (grant_next && (hold_q < HOLD_MAX)),
        .q     (hold_q)
    );

    // Dead-gap timer: starts at 1 on the edge the gap is entered.
    sat_counter #(.W(GW)) u_gap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_d != GAP),
        .inc   ((state_d == GAP) && (gap_q < GAP_MAX)),
        .q     (gap_q)
    );

    // Switchover counter: only ever cleared by reset.
    sat_counter #(.W(CNT_W)) u_switch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (switch_inc),
        .q     (switch_cnt)
    );

    // Next-state, select and last-owner decisions.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        switch_inc = 1'b0;
        other_req  = (last_q == SEL_A) ? req_b : req_a;
        pick       = idle_pick(req_a, req_b, last_q);

        case (state_q)
            IDLE: begin
                state_d = pick;
                if (pick != IDLE) begin
                    sel_d = grant_sel(pick);
                end
            end
            GRANT_A: begin
                if (!req_a || (req_b && (hold_q >= HOLD_MAX))) begin
                    last_d  = SEL_A;
                    state_d = req_b ? GAP : IDLE;
                end
            end
            GRANT_B: begin
                if (!req_b || (req_a && (hold_q >= HOLD_MAX))) begin
                    last_d  = SEL_B;
                    state_d = req_a ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q >= GAP_MAX) begin
                    if (other_req) begin
                        state_d    = (last_q == SEL_A) ? GRANT_B : GRANT_A;
                        sel_d      = ~last_q;
                        switch_inc = 1'b1;
                    end else begin
                        // Other source gave up during the gap: behave as idle.
                        state_d = pick;
                        if (pick != IDLE) begin
                            sel_d = grant_sel(pick);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; grants are decoded from the next state
    // so they rise on the same edge as the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= SEL_A;
            last_q    <= SEL_B;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            grant_a_q <= (state_d == GRANT_A);
            grant_b_q <= (state_d == GRANT_B);
        end
    end

    assign sel     = sel_q;
    assign grant_a = grant_a_q;
    assign grant_b = grant_b_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: a wide-counter instance and a 2-bit-counter
// instance share the same stimulus; both are checked every cycle against an
// ownership model, plus a hand-derived vector table and directed sequences.
module tb_mux_sel_arbiter;

    localparam int HOLD = 4;
    localparam int GAPC = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b;
    logic       sel, ga, gb;
    logic [7:0] cnt;
    logic       sel_s, ga_s, gb_s;
    logic [1:0] cnt_s;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .req_b      (req_b),
        .sel        (sel),
        .grant_a    (ga),
        .grant_b    (gb),
        .switch_cnt (cnt)
    );

    mux_sel_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC), .CNT_W(2)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .req_b      (req_b),
        .sel        (sel_s),
        .grant_a    (ga_s),
        .grant_b    (gb_s),
        .switch_cnt (cnt_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Ownership model: owner -1 = nobody, 0 = a, 1 = b.
    int m_owner, m_held, m_gap, m_last, m_sel, m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_gap = 0; m_last = 1; m_sel = 0; m_cnt = 0;
    endtask

    task automatic model_grant(input int who);
        m_owner = who; m_sel = who; m_held = 1; m_gap = 0;
    endtask

    task automatic model_pick(input bit ra, input bit rb);
        if (ra && rb) model_grant(1 - m_last);
        else if (ra)  model_grant(0);
        else if (rb)  model_grant(1);
    endtask

    // One clock edge worth of arbitration, decided from the requests
    // present before the edge.
    task automatic model_step(input bit ra, input bit rb);
        bit rq[2];
        int other;
        rq[0] = ra;
        rq[1] = rb;
        if (m_owner >= 0) begin
            other = 1 - m_owner;
            if (!rq[m_owner] || (rq[other] && m_held >= HOLD)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = rq[other] ? GAPC : 0;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            if (m_gap == 1) begin
                m_gap = 0;
                if (rq[1 - m_last]) begin
                    model_grant(1 - m_last);
                    m_cnt++;
                end else begin
                    model_pick(ra, rb);
                end
            end else begin
                m_gap--;
            end
        end else begin
            model_pick(ra, rb);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " grant_a"},   int'(ga),    int'(m_owner == 0));
        chk({tag, " grant_b"},   int'(gb),    int'(m_owner == 1));
        chk({tag, " sel"},       int'(sel),   m_sel);
        chk({tag, " cnt"},       int'(cnt),   (m_cnt > 255) ? 255 : m_cnt);
        chk({tag, " grant_a_s"}, int'(ga_s),  int'(m_owner == 0));
        chk({tag, " grant_b_s"}, int'(gb_s),  int'(m_owner == 1));
        chk({tag, " sel_s"},     int'(sel_s), m_sel);
        chk({tag, " cnt_s"},     int'(cnt_s), (m_cnt > 3) ? 3 : m_cnt);
    endtask

    // Drive requests just after an edge, advance the model, check after the next edge.
    task automatic do_cycle(input bit ra, input bit rb, input string tag);
        req_a = ra;
        req_b = rb;
        model_step(ra, rb);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " sel"},     int'(sel),   0);
        chk({tag, " grant_a"}, int'(ga),    0);
        chk({tag, " grant_b"}, int'(gb),    0);
        chk({tag, " cnt"},     int'(cnt),   0);
        chk({tag, " cnt_s"},   int'(cnt_s), 0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic apply_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Grant invariants, sampled on the falling edge.
    logic prev_sel, prev_any;
    bit   prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            n_cmp++;
            assert (!(ga && gb) && !(ga_s && gb_s)) else begin
                n_bad++;
                $display("FAIL onehot: grant_a=%0b grant_b=%0b required not both 1 (t=%0t)", ga, gb, $time);
            end
            if (prev_valid) begin
                n_cmp++;
                assert ((sel == prev_sel) || (!prev_any && (ga || gb))) else begin
                    n_bad++;
                    $display("FAIL sel_change: sel %0b->%0b with prev_any=%0b grants=%0b%0b (t=%0t)",
                             prev_sel, sel, prev_any, ga, gb, $time);
                end
            end
            prev_sel   = sel;
            prev_any   = ga || gb;
            prev_valid = 1'b1;
        end
    end

    typedef struct {
        bit ra;
        bit rb;
        bit ga;
        bit gb;
        bit sel;
        int cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Contention from reset, early release, idle re-grant.
        tbl[0]  = '{1, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 1, 1};
        tbl[6]  = '{1, 1, 0, 1, 1, 1};
        tbl[7]  = '{1, 1, 0, 1, 1, 1};
        tbl[8]  = '{1, 1, 0, 1, 1, 1};
        tbl[9]  = '{1, 1, 0, 0, 1, 1};
        tbl[10] = '{1, 1, 1, 0, 0, 2};
        tbl[11] = '{0, 1, 0, 0, 0, 2};
        tbl[12] = '{0, 1, 0, 1, 1, 3};
        tbl[13] = '{0, 0, 0, 0, 1, 3};
        tbl[14] = '{1, 0, 1, 0, 0, 3};
        tbl[15] = '{0, 0, 0, 0, 0, 3};

        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        model_reset();
        #12;
        check_reset_vals("reset_init");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_cycle(tbl[i].ra, tbl[i].rb, $sformatf("vec%0d", i));
            chk($sformatf("tbl%0d grant_a", i), int'(ga),    int'(tbl[i].ga));
            chk($sformatf("tbl%0d grant_b", i), int'(gb),    int'(tbl[i].gb));
            chk($sformatf("tbl%0d sel", i),     int'(sel),   int'(tbl[i].sel));
            chk($sformatf("tbl%0d cnt", i),     int'(cnt),   tbl[i].cnt);
            chk($sformatf("tbl%0d cnt_s", i),   int'(cnt_s), (tbl[i].cnt > 3) ? 3 : tbl[i].cnt);
        end

        // Reset in the middle of a b grant with a nonzero switch count.
        do_cycle(0, 1, "pre_reset");
        chk("pre_reset grant_b", int'(gb), 1);
        apply_reset("reset_mid_grant");

        // Single source: one-cycle latency, release on the next edge.
        do_cycle(1, 0, "single");
        chk("single grant_a", int'(ga), 1);
        chk("single sel", int'(sel), 0);
        do_cycle(1, 0, "single_hold");
        do_cycle(0, 0, "single_drop");
        chk("single_drop grant_a", int'(ga), 0);

        // Early release: a drops at hold 2 while b waits; no hold wait.
        do_cycle(1, 0, "early0");
        do_cycle(1, 1, "early1");
        do_cycle(0, 1, "early_rel");
        chk("early_rel grant_a", int'(ga), 0);
        chk("early_rel grant_b", int'(gb), 0);
        do_cycle(0, 1, "early_grant");
        chk("early_grant grant_b", int'(gb), 1);
        chk("early_grant cnt", int'(cnt), 1);

        // Gap abandon: run b to its hold limit, then withdraw everything in the gap.
        for (int k = 0; k < 8 && !(m_owner < 0 && m_gap > 0); k++) begin
            do_cycle(1, 1, "to_gap");
        end
        chk("gap_reached grants", int'(ga || gb), 0);
        do_cycle(0, 0, "gap_abandon");
        chk("gap_abandon grants", int'(ga || gb), 0);
        chk("gap_abandon sel", int'(sel), 1);
        chk("gap_abandon cnt", int'(cnt), 1);

        // Saturation: sustained contention drives many switchovers.
        for (int k = 0; k < 60; k++) begin
            do_cycle(1, 1, "alt");
        end
        chk("sat cnt_s", int'(cnt_s), 3);
        chk("sat wide cnt above 4", int'(cnt > 8'd4), 1);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset("rand_reset");
            end else begin
                do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
